// File: rtl/piso_tx_ctrl.sv
// piso_tx_ctrl: frame sequencer for an MSB-first PISO, forming a UART-style serial transmitter
// Ports: clk; reset (async, active-low); tx_data/tx_valid/tx_ready accept one word in IDLE;
// tx_abort drops the frame in flight; tx_busy marks LOAD/SHIFT; tx_done pulses after the stop bit;
// piso_enb/piso_load/piso_shift/piso_fsm_rst drive the PISO and piso_inp is the frame it loads.
// Build option: define TX_PARITY_EN to send an even-parity bit before the stop bit (FRAME_W = DATA_W+3).
module piso_tx_ctrl #(
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 16,
`ifdef TX_PARITY_EN
  localparam int FRAME_W = DATA_W + 3
`else
  localparam int FRAME_W = DATA_W + 2
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic               tx_valid,
  output logic               tx_ready,
  input  logic               tx_abort,
  output logic               tx_busy,
  output logic               tx_done,
  output logic               piso_enb,
  output logic               piso_load,
  output logic               piso_shift,
  output logic               piso_fsm_rst,
  output logic [FRAME_W-1:0] piso_inp
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(FRAME_W);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_PRE  = BW'(BAUD_DIV - 2);
  localparam logic [CW-1:0] BIT_LAST  = CW'(FRAME_W - 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [CW-1:0] bit_q, bit_d;
  logic [FRAME_W-1:0] inp_q, inp_d, frame;
  logic [DATA_W-1:0] data_rev;
  logic ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic enb_q, enb_d, load_q, load_d, shift_q, shift_d, fsm_rst_q, fsm_rst_d;
  // The PISO sends its MSB first but the line wants data LSB first, so the word goes in reversed.
  for (genvar i = 0; i < DATA_W; i++) begin : g_rev
    assign data_rev[i] = tx_data[DATA_W-1-i];
  end
`ifdef TX_PARITY_EN
  assign frame = {1'b0, data_rev, ^tx_data, 1'b1};
`else
  assign frame = {1'b0, data_rev, 1'b1};
`endif
  // Outputs are registered, so each pulse is decided one cycle early: the shift strobe is
  // raised from baud_cnt==BAUD_DIV-2 and therefore is visible while baud_cnt==BAUD_DIV-1.
  // tx_ready stays low in the tx_done cycle so the next accept cannot overlap the stop bit.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    inp_d     = inp_q;
    ready_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    load_d    = 1'b0;
    shift_d   = 1'b0;
    fsm_rst_d = 1'b1;
    case (state_q)
      IDLE: begin
        if (tx_valid && ready_q) begin
          state_d = LOAD;
          inp_d   = frame;
          busy_d  = 1'b1;
          load_d  = 1'b1;
        end else ready_d = 1'b1;
      end
      LOAD: begin
        baud_d = '0;
        bit_d  = '0;
        if (tx_abort) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else begin
          state_d   = SHIFT;
          busy_d    = 1'b1;
          fsm_rst_d = 1'b0;
        end
      end
      default: begin
        baud_d = (baud_q == BAUD_LAST) ? '0 : baud_q + 1'b1;
        if (tx_abort) begin
          state_d = IDLE;
          ready_d = 1'b1;
        end else if (baud_q == BAUD_LAST && bit_q == BIT_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d    = 1'b1;
          fsm_rst_d = 1'b0;
          bit_d     = (baud_q == BAUD_LAST) ? bit_q + 1'b1 : bit_q;
          shift_d   = (baud_q == BAUD_PRE) && (bit_q != BIT_LAST);
        end
      end
    endcase
    enb_d = load_d | shift_d;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      inp_q     <= '1;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      enb_q     <= 1'b0;
      load_q    <= 1'b0;
      shift_q   <= 1'b0;
      fsm_rst_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      inp_q     <= inp_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      enb_q     <= enb_d;
      load_q    <= load_d;
      shift_q   <= shift_d;
      fsm_rst_q <= fsm_rst_d;
    end
  end
  assign tx_ready     = ready_q;
  assign tx_busy      = busy_q;
  assign tx_done      = done_q;
  assign piso_enb     = enb_q;
  assign piso_load    = load_q;
  assign piso_shift   = shift_q;
  assign piso_fsm_rst = fsm_rst_q;
  assign piso_inp     = inp_q;
endmodule

// File: tb/tb_piso_tx_ctrl.sv
// tb_piso_tx_ctrl: self-checking bench for piso_tx_ctrl with a behavioural PISO and frame model
module tb_piso_tx_ctrl;
  localparam int DW = 8;
  localparam int BD = 4;
`ifdef TX_PARITY_EN
  localparam int FW = DW + 3;
`else
  localparam int FW = DW + 2;
`endif
  typedef struct {
    logic [DW-1:0] w;
    logic [FW-1:0] exp;
    bit            keep;
    int            kind;
    int            cut;
    int            gap_exp;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic tx_valid = 1'b0;
  logic tx_abort = 1'b0;
  logic tx_ready, tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_rst;
  logic [FW-1:0] piso_inp;
  logic [FW-1:0] sh = '1;
  logic line;
  int n_checks = 0;
  int n_errors = 0;

  piso_tx_ctrl #(.DATA_W(DW), .BAUD_DIV(BD)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_abort(tx_abort), .tx_busy(tx_busy), .tx_done(tx_done), .piso_enb(piso_enb),
    .piso_load(piso_load), .piso_shift(piso_shift), .piso_fsm_rst(piso_fsm_rst), .piso_inp(piso_inp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (piso_enb && piso_load) sh <= piso_inp;
    else if (piso_enb && piso_shift) sh <= {sh[FW-2:0], 1'b0};
  end
  assign line = piso_fsm_rst ? 1'b1 : sh[FW-1];

  function automatic logic [FW-1:0] model_frame(input logic [DW-1:0] w);
    int b[$];
    logic [FW-1:0] f;
    b.push_back(0);
    for (int i = 0; i < DW; i++) b.push_back(int'((w >> i) & 8'd1));
`ifdef TX_PARITY_EN
    b.push_back($countones(w) % 2);
`endif
    b.push_back(1);
    for (int j = 0; j < FW; j++) f[FW-1-j] = (b[j] != 0);
    return f;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // kind: 0 full frame, 1 abort in line cycle cut, 2 async reset in line cycle cut
  task automatic frame(input logic [DW-1:0] w, input logic [FW-1:0] exp, input bit keep,
                       input logic [DW-1:0] nxt, input int kind, input int cut, output int gap);
    int shifts;
    shifts = 0;
    gap = 0;
    while (!tx_ready && gap < 100) begin
      @(negedge clk);
      gap++;
    end
    chk("ready_before_accept", tx_ready, 1);
    tx_data = w;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = keep;
    tx_data = keep ? nxt : DW'($urandom);
    chk("load_cycle", {piso_load, piso_enb, piso_shift, tx_busy, tx_ready, piso_fsm_rst}, 6'b110101);
    chk("frame_word", piso_inp, exp);
    for (int k = 1; k <= FW * BD; k++) begin
      @(negedge clk);
      shifts += int'(piso_shift);
      chk("line_cycle", {line, tx_done, tx_busy, tx_ready, piso_load, piso_fsm_rst},
          {exp[FW-1-(k-1)/BD], 5'b01000});
      if (kind == 1 && k == cut) begin
        tx_abort = 1'b1;
        @(negedge clk);
        tx_abort = 1'b0;
        chk("abort_idle", {line, tx_done, tx_busy, tx_ready, piso_fsm_rst, piso_shift, piso_load}, 7'b1001100);
        repeat (2 * BD) begin
          @(negedge clk);
          chk("abort_no_done", {tx_done, tx_busy}, 0);
        end
        return;
      end
      if (kind == 2 && k == cut) begin
        tx_valid = 1'b0;
        #1 reset = 1'b0;
        #1 chk("reset_async", {tx_ready, tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_rst, line}, 8'b00000011);
        chk("reset_inp", piso_inp, {FW{1'b1}});
        repeat (2) begin
          @(negedge clk);
          chk("reset_hold", {tx_ready, tx_done, tx_busy}, 0);
        end
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_release", {tx_ready, piso_fsm_rst, tx_busy, tx_done}, 4'b1100);
        return;
      end
    end
    @(negedge clk);
    chk("done_pulse", {tx_done, tx_ready, tx_busy, piso_fsm_rst, line}, 5'b10011);
    chk("shift_count", shifts, FW - 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v[$];
    int gap;
    logic [DW-1:0] cur, nxt;
    bit keep, prev_keep;
    int kind;
`ifdef TX_PARITY_EN
    v.push_back('{w: 8'h07, exp: 11'b01110000011, keep: 0, kind: 0, cut: 0, gap_exp: -1});
    v.push_back('{w: 8'hA5, exp: 11'b01010010101, keep: 0, kind: 0, cut: 0, gap_exp: -1});
`else
    v.push_back('{w: 8'hA5, exp: 10'b0101001011, keep: 0, kind: 0, cut: 0, gap_exp: -1});
    v.push_back('{w: 8'h00, exp: 10'b0000000001, keep: 1, kind: 0, cut: 0, gap_exp: -1});
    v.push_back('{w: 8'hFF, exp: 10'b0111111111, keep: 0, kind: 0, cut: 0, gap_exp: 1});
    v.push_back('{w: 8'h3C, exp: 10'b0001111001, keep: 0, kind: 1, cut: 14, gap_exp: -1});
    v.push_back('{w: 8'h5A, exp: 10'b0010110101, keep: 0, kind: 0, cut: 0, gap_exp: 0});
    v.push_back('{w: 8'hC3, exp: 10'b0110000111, keep: 0, kind: 2, cut: 20, gap_exp: -1});
    v.push_back('{w: 8'h96, exp: 10'b0011010011, keep: 0, kind: 0, cut: 0, gap_exp: 0});
`endif
    repeat (3) @(negedge clk);
    chk("reset_vals", {tx_ready, tx_busy, tx_done, piso_enb, piso_load, piso_shift, piso_fsm_rst, line}, 8'b00000011);
    chk("reset_inp", piso_inp, {FW{1'b1}});
    reset = 1'b1;
    @(negedge clk);
    chk("ready_first_clock", {tx_ready, piso_fsm_rst, line, piso_enb, piso_load, piso_shift, tx_busy, tx_done}, 8'b11100000);
    repeat (6) begin
      @(negedge clk);
      chk("idle_quiet", {tx_ready, piso_fsm_rst, line, piso_enb, piso_load, piso_shift, tx_busy, tx_done}, 8'b11100000);
    end
    for (int i = 0; i < v.size(); i++) begin
      nxt = (i + 1 < v.size()) ? v[i+1].w : '0;
      frame(v[i].w, v[i].exp, v[i].keep, nxt, v[i].kind, v[i].cut, gap);
      if (v[i].gap_exp >= 0) chk("accept_gap", gap, v[i].gap_exp);
    end
    repeat (3) @(negedge clk);
    cur = DW'($urandom);
    prev_keep = 0;
    for (int i = 0; i < 25; i++) begin
      nxt = DW'($urandom);
      kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
      keep = (kind == 0) && (i < 24) && ($urandom_range(0, 2) == 0);
      frame(cur, model_frame(cur), keep, nxt, kind, $urandom_range(1, FW * BD), gap);
      if (prev_keep) chk("rand_b2b_gap", gap, 1);
      prev_keep = keep;
      cur = nxt;
      if (!keep) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
